// File: rtl/keypad_pkg.sv
// keypad_pkg: shared key codes, FSM state encoding and keypad index types
package keypad_pkg;
    localparam int CNT_W = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;
    typedef logic [1:0] row_t;
    typedef logic [1:0] col_t;
    typedef enum logic [1:0] {IDLE, BOUNCE, HOLD, GAP} state_t;
endpackage

// File: rtl/keypad_key_decoder.sv
// keypad_key_decoder: maps a key code to its validity and row/column on the 4x3 keypad
module keypad_key_decoder
    import keypad_pkg::*;
(
    input  logic [3:0] key_code,
    output logic       valid,
    output row_t       row,
    output col_t       col
);
    logic [3:0] k;
    // digits 1..9 fill rows 0..2 left to right; '*', 0, '#' share row 3
    assign k = key_code - 4'd1;
    assign valid = key_code <= KEY_HASH;
    assign row = (key_code == 4'd0 || key_code >= KEY_STAR) ? 2'd3 : row_t'(k / 4'd3);
    assign col = key_code == 4'd0 ? 2'd1 :
                 key_code == KEY_STAR ? 2'd0 :
                 key_code == KEY_HASH ? 2'd2 : col_t'(k % 4'd3);
endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: presses one key on a row-driven 4x3 keypad with optional bounce, hold and release gap
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES   = 16,
    parameter int GAP_CYCLES    = 8,
    parameter int BOUNCE_CYCLES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [3:0] Row,
    output logic [2:0] Col,
    output logic       busy,
    output logic       done,
    output logic       key_err
);
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > CNT_MAX || GAP_CYCLES < 1 || GAP_CYCLES > CNT_MAX ||
        BOUNCE_CYCLES < 0 || BOUNCE_CYCLES > CNT_MAX) begin : g_bad_param
        $error("keypad_emulator: cycle parameters must fit the 16-bit counter");
    end

    localparam logic [CNT_W-1:0] B_LOAD = BOUNCE_CYCLES > 0 ? CNT_W'(BOUNCE_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] H_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] G_LOAD = CNT_W'(GAP_CYCLES - 1);

    state_t           state, state_n;
    logic             contact, contact_n;
    row_t             row_q, row_n;
    col_t             col_q, col_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             done_n, err_n;
    logic             dec_valid;
    row_t             dec_row;
    col_t             dec_col;
    logic             accept;

    keypad_key_decoder u_dec (
        .key_code (key_code),
        .valid    (dec_valid),
        .row      (dec_row),
        .col      (dec_col)
    );

    assign key_ready = state == IDLE;
    assign busy = state != IDLE;
    assign accept = key_valid && key_ready;
    // switch model: the closed contact shorts the latched row onto the latched column
    assign Col = (contact && !Row[row_q]) ? ~(3'b001 << col_q) : 3'b111;

    always_comb begin
        state_n = state;
        contact_n = contact;
        row_n = row_q;
        col_n = col_q;
        cnt_n = cnt;
        done_n = 1'b0;
        err_n = 1'b0;
        case (state)
            IDLE: if (accept) begin
                if (dec_valid) begin
                    row_n = dec_row;
                    col_n = dec_col;
                    contact_n = 1'b1;
                    state_n = BOUNCE_CYCLES > 0 ? BOUNCE : HOLD;
                    cnt_n = BOUNCE_CYCLES > 0 ? B_LOAD : H_LOAD;
                end else begin
                    err_n = 1'b1;
                end
            end
            BOUNCE: begin
                state_n = cnt == '0 ? HOLD : BOUNCE;
                cnt_n = cnt == '0 ? H_LOAD : cnt - 1'b1;
                contact_n = cnt == '0 ? 1'b1 : ~contact;
            end
            HOLD: begin
                state_n = cnt == '0 ? GAP : HOLD;
                cnt_n = cnt == '0 ? G_LOAD : cnt - 1'b1;
                contact_n = cnt != '0;
            end
            GAP: begin
                state_n = cnt == '0 ? IDLE : GAP;
                cnt_n = cnt == '0 ? '0 : cnt - 1'b1;
                done_n = cnt == '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            contact <= 1'b0;
            row_q <= '0;
            col_q <= '0;
            cnt <= '0;
            done <= 1'b0;
            key_err <= 1'b0;
        end else begin
            state <= state_n;
            contact <= contact_n;
            row_q <= row_n;
            col_q <= col_n;
            cnt <= cnt_n;
            done <= done_n;
            key_err <= err_n;
        end
    end
endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 The module SHALL have parameter HOLD_CYCLES, default 16, meaning the number of clock cycles the contact stays fully closed (range 1..65535).
REQ-002 The module SHALL have parameter GAP_CYCLES, default 8, meaning the number of clock cycles the contact stays open after release before the next press is accepted (range 1..65535).
REQ-003 The module SHALL have parameter BOUNCE_CYCLES, default 0, meaning the length in cycles of the contact-bounce phase before HOLD (0 disables bounce).
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 key_code  input  4  key to press: 0x0-0x9 are digits, 0xA is '*', 0xB is '#', and 0xC-0xF are invalid.
REQ-007 key_valid  input  1  press request, qualified by key_ready.
REQ-008 key_ready  output  1  high only in IDLE; a press is accepted on a rising edge with key_valid & key_ready.
REQ-009 Row  input  4  scan lines from the keypad encoder, active-low (0 = row driven).
REQ-010 Col  output  3  column sense lines, active-low (all-ones = no key).
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when GAP completes.
REQ-013 key_err  output  1  one-cycle pulse the cycle after an invalid code is accepted.

Function
REQ-014 The key map SHALL be row0 = {1,2,3}, row1 = {4,5,6}, row2 = {7,8,9}, row3 = {*,0,#}, with columns 0,1,2 running left to right.
REQ-015 The state machine SHALL have the states IDLE, BOUNCE, HOLD and GAP, with a registered state, registered row/column index latches and a 16-bit down-counter.
REQ-016 On acceptance of a valid code, the module SHALL latch its row and column and enter BOUNCE the next cycle if BOUNCE_CYCLES > 0, otherwise HOLD.
REQ-017 On acceptance of an invalid code, the module SHALL stay in IDLE, pulse key_err for one cycle, leave Col unchanged, and keep key_ready high.
REQ-018 In BOUNCE, the registered contact SHALL toggle every cycle starting closed, for exactly BOUNCE_CYCLES cycles, then go to HOLD.
REQ-019 In HOLD, the contact SHALL be closed for exactly HOLD_CYCLES cycles, then go to GAP.
REQ-020 In GAP, the contact SHALL be open for exactly GAP_CYCLES cycles; on the last GAP cycle done SHALL pulse and the next state SHALL be IDLE.
REQ-021 Col[c] SHALL be 0 if and only if the contact is closed, c equals the latched column, and Row[latched row] is 0; otherwise Col[c] SHALL be 1.
REQ-022 Col SHALL be combinational from Row (a switch model) with no clock latency from Row to Col.
REQ-023 Behaviour with Row non-one-hot or all-ones SHALL follow REQ-021 unchanged; no error is raised.
REQ-024 key_valid while busy SHALL be ignored, with no queuing.
REQ-025 done and key_err SHALL never both be high in the same cycle.
REQ-026 Total press latency SHALL be accept edge -> contact closed at the next cycle -> done asserted BOUNCE_CYCLES + HOLD_CYCLES + GAP_CYCLES cycles after the first closed cycle.

Reset
REQ-027 While reset is high, the module SHALL hold state = IDLE, contact open, Col = 3'b111, key_ready = 1, busy = 0, done = 0, key_err = 0, counter = 0, and latches = 0.
REQ-028 Reset asserted mid-press SHALL immediately force Col to 3'b111 without waiting for a clock edge.
REQ-029 After reset deasserts, the first press SHALL be accepted on the first valid rising edge.

Structure
REQ-030 The shared package keypad_pkg SHALL hold the key-code constants (KEY_STAR = 4'hA, KEY_HASH = 4'hB), the state enum, and the row/column index types.
REQ-031 A combinational sub-module keypad_key_decoder SHALL map key_code to {valid, row[1:0], col[1:0]} and be reusable by the encoder's bench.
REQ-032 The counter width SHALL be 16 bits; parameters exceeding 16 bits SHALL be rejected at elaboration.

Verification
REQ-033 The bench SHALL drive key_code = 0x5 with defaults and Row cycling 1110 -> 1101 -> 1011 -> 0111, and SHALL check that Col = 101 only while Row = 1101 during HOLD, and that done pulses 24 cycles after the first closed cycle.
REQ-034 The bench SHALL drive key_code = 0xB with Row held at 0111, and SHALL check that Col = 011 for exactly 16 cycles, then 111 for 8 cycles, then done.
REQ-035 The bench SHALL drive key_code = 0xE, and SHALL check that key_err pulses once, Col stays 111, busy stays 0, and key_ready stays 1.
REQ-036 The bench SHALL run BOUNCE_CYCLES = 4 with key_code = 0x1 and Row = 1110, and SHALL check that Col[0] reads 0,1,0,1 over the bounce phase and then holds 0 for 16 cycles.
REQ-037 The bench SHALL assert key_valid with key_code = 0x2 during the HOLD of key 0x8, and SHALL check that it is ignored and that the latched column stays at 1 with row 2.
REQ-038 The bench SHALL assert reset in the middle of HOLD with Row = 1011 and key_code = 0x9, and SHALL check that Col = 111 within the same cycle and that key_ready = 1 after release.
